// File: rtl/stack_buf.sv
// rtl/stack_buf.sv - parametrised LIFO stack with flags and sticky errors
module stack_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  iCLK,
    input  logic                  iRESET,
    input  logic                  iCLR,
    input  logic                  iPUSH,
    input  logic                  iPOP,
    input  logic [DATA_WIDTH-1:0] iDATA,
    output logic [DATA_WIDTH-1:0] oDATA,
    output logic [ADDR_WIDTH:0]   oCOUNT,
    output logic                  oFULL,
    output logic                  oEMPTY,
    output logic                  oALMOST_FULL,
    output logic                  oALMOST_EMPTY,
    output logic                  oOVF,
    output logic                  oUDF
);

    localparam int CW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] top_idx;
    logic                  full, empty;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    // Low bits wrap at full (count == DEPTH) to index DEPTH-1, which is the true top.
    assign top_idx = count_q[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        wr_en   = 1'b0;
        wr_addr = '0;
        if (iCLR) begin
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else if (iPUSH && iPOP) begin
            wr_en = 1'b1;
            if (empty) begin
                count_d = CW'(1);
                udf_d   = 1'b1;
            end else begin
                wr_addr = top_idx;
            end
        end else if (iPUSH) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                wr_en   = 1'b1;
                wr_addr = count_q[ADDR_WIDTH-1:0];
                count_d = count_q + CW'(1);
            end
        end else if (iPOP) begin
            if (empty) udf_d = 1'b1;
            else       count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage is deliberately unreset; count alone defines which entries are valid.
    always_ff @(posedge iCLK) begin
        if (wr_en) mem_q[wr_addr] <= iDATA;
    end

    assign oDATA         = empty ? '0 : mem_q[top_idx];
    assign oCOUNT        = count_q;
    assign oFULL         = full;
    assign oEMPTY        = empty;
    assign oALMOST_FULL  = (count_q >= AF_C);
    assign oALMOST_EMPTY = (count_q <= AE_C);
    assign oOVF          = ovf_q;
    assign oUDF          = udf_q;

endmodule

// File: tb/tb_stack_buf.sv
// tb/tb_stack_buf.sv - randomized and directed check of stack_buf against a queue model
module tb_stack_buf;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 2 ** AW;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;
    logic [AW:0]   cnt;
    logic          full, empty, afull, aempty, ovf, udf;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] m_q[$];
    bit            m_ovf = 0;
    bit            m_udf = 0;

    stack_buf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .iCLK(clk), .iRESET(rst), .iCLR(clr), .iPUSH(push), .iPOP(pop), .iDATA(din),
        .oDATA(dout), .oCOUNT(cnt), .oFULL(full), .oEMPTY(empty),
        .oALMOST_FULL(afull), .oALMOST_EMPTY(aempty), .oOVF(ovf), .oUDF(udf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = m_q.size();
        check({tag, ".count"},  32'(cnt),    32'(sz));
        check({tag, ".empty"},  32'(empty),  32'(sz == 0));
        check({tag, ".full"},   32'(full),   32'(sz == DEPTH));
        check({tag, ".afull"},  32'(afull),  32'(sz >= AF));
        check({tag, ".aempty"}, 32'(aempty), 32'(sz <= AE));
        check({tag, ".ovf"},    32'(ovf),    32'(m_ovf));
        check({tag, ".udf"},    32'(udf),    32'(m_udf));
        check({tag, ".data"},   32'(dout),   (sz == 0) ? 32'd0 : 32'(m_q[sz-1]));
    endtask

    task automatic model(input bit c, input bit pu, input bit po, input logic [DW-1:0] d);
        int sz;
        sz = m_q.size();
        if (c) begin
            m_q.delete();
            m_ovf = 0;
            m_udf = 0;
        end else if (pu && po) begin
            if (sz == 0) begin
                m_q.push_back(d);
                m_udf = 1;
            end else begin
                m_q[sz-1] = d;
            end
        end else if (pu) begin
            if (sz == DEPTH) m_ovf = 1;
            else             m_q.push_back(d);
        end else if (po) begin
            if (sz == 0) m_udf = 1;
            else         void'(m_q.pop_back());
        end
    endtask

    task automatic step(input string tag, input bit c, input bit pu, input bit po,
                        input logic [DW-1:0] d);
        @(negedge clk);
        clr  = c;
        push = pu;
        pop  = po;
        din  = d;
        @(posedge clk);
        model(c, pu, po, d);
        #1;
        check_all(tag);
    endtask

    initial begin
        int r, bias;
        if (!(AE >= 0 && AE < AF && AF <= DEPTH))
            $fatal(1, "FAIL param_legality: AE=%0d AF=%0d DEPTH=%0d", AE, AF, DEPTH);

        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 1; i <= DEPTH; i++) step("fill", 0, 1, 0, DW'(i));
        check("fill.full_cnt", 32'(cnt), 32'd16);
        step("ovf", 0, 1, 0, 8'hEE);
        check("ovf.data_kept", 32'(dout), 32'h10);
        step("rep_full", 0, 1, 1, 8'h77);
        for (int i = 0; i < DEPTH; i++) step("drain", 0, 0, 1, 8'h00);
        step("udf", 0, 0, 1, 8'h00);
        step("clr", 1, 0, 0, 8'h00);
        step("udf2", 0, 0, 1, 8'h00);
        step("clr2", 1, 0, 0, 8'h00);

        step("rep_a", 0, 1, 0, 8'hAA);
        step("rep_b", 0, 1, 0, 8'hBB);
        step("rep_c", 0, 1, 1, 8'hCC);
        check("rep.data", 32'(dout), 32'hCC);
        step("rep_pop", 0, 0, 1, 8'h00);
        check("rep_pop.data", 32'(dout), 32'hAA);
        step("clr3", 1, 0, 0, 8'h00);
        step("pp_empty", 0, 1, 1, 8'h55);
        check("pp_empty.data", 32'(dout), 32'h55);

        step("clr4", 1, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) step("to5", 0, 1, 0, DW'(8'h30 + i));
        step("clr_prio", 1, 1, 0, 8'h99);
        step("after_clr_pop", 0, 0, 1, 8'h00);

        step("clr5", 1, 0, 0, 8'h00);
        for (int i = 0; i < 7; i++) step("to7", 0, 1, 0, DW'(8'h60 + i));
        @(negedge clk);
        push = 1'b1;
        din  = 8'h42;
        #2;
        rst = 1'b1;
        #1;
        m_q.delete();
        m_ovf = 0;
        m_udf = 0;
        check_all("async_rst");
        push = 1'b0;
        #1;
        rst = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            bias = ((n / 200) % 3 == 0) ? 70 : (((n / 200) % 3 == 1) ? 30 : 50);
            r = $urandom_range(0, 99);
            if (r < 2) begin
                step("rnd", 1, $urandom_range(0, 1), $urandom_range(0, 1), DW'($urandom));
            end else begin
                r = $urandom_range(0, 99);
                if (r < 10)        step("rnd", 0, 1, 1, DW'($urandom));
                else if (r < 10 + bias * 80 / 100) step("rnd", 0, 1, 0, DW'($urandom));
                else if (r < 95)   step("rnd", 0, 0, 1, DW'($urandom));
                else               step("rnd", 0, 0, 0, DW'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stack_buf.md
# stack_buf

Parametrised LIFO stack with integrated register-file storage, occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It supports a single-cycle replace-top operation on simultaneous push and pop, and a synchronous clear. It is the self-contained stack for datapaths that need a stack: expression evaluators, return-address stacks and parsers. No external RAM or pointer glue is needed.

## Interface
Parameters:
- DATA_WIDTH, 8, width of each stack entry
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH entries, all usable
- AF_LEVEL, DEPTH-2, oALMOST_FULL asserted when count >= AF_LEVEL
- AE_LEVEL, 2, oALMOST_EMPTY asserted when count <= AE_LEVEL

Ports:
- Clock and reset: reset iRESET, asynchronous, active-high; clock iCLK.
- iCLK  in  1  clock, all state changes on rising edge
- iRESET  in  1  async active-high reset
- iCLR  in  1  synchronous clear: empties stack and clears error flags
- iPUSH  in  1  push request
- iPOP  in  1  pop request
- iDATA  in  DATA_WIDTH  data to push or replace
- oDATA  out  DATA_WIDTH  current top of stack; 0 when empty
- oCOUNT  out  ADDR_WIDTH+1  number of stored entries, 0..DEPTH
- oFULL  out  1  count == DEPTH
- oEMPTY  out  1  count == 0
- oALMOST_FULL  out  1  count >= AF_LEVEL
- oALMOST_EMPTY  out  1  count <= AE_LEVEL
- oOVF  out  1  sticky: push rejected while full
- oUDF  out  1  sticky: pop rejected while empty

## Operation
- State: count register (ADDR_WIDTH+1 bits), DEPTH x DATA_WIDTH register array, oOVF and oUDF registers.
- The storage array is not reset.
- Entry i is at mem[i]; the top is mem[count-1]. oDATA = (count==0) ? 0 : mem[count-1], combinational from registers.
- All flags decode combinationally from the count register only. They never depend on the current inputs.
- Per-cycle action, in priority order:
  - iCLR=1: count <= 0; oOVF, oUDF <= 0. Push and pop are ignored; no memory write.
  - push only, not full: mem[count] <= iDATA; count <= count+1.
  - push only, full: no change; oOVF <= 1.
  - pop only, not empty: count <= count-1. Data is not erased.
  - pop only, empty: no change; oUDF <= 1.
  - push and pop, not empty (including full): replace top. mem[count-1] <= iDATA; count unchanged; no error.
  - push and pop, empty: behaves as push (mem[0] <= iDATA, count <= 1); oUDF <= 1.
  - neither: hold.
- Sticky flags remain set until iCLR or iRESET.
- Count arithmetic is unsigned ADDR_WIDTH+1 bits and never wraps. Rejected operations guarantee count stays in 0..DEPTH.
- Parameter legality: 0 <= AE_LEVEL < AF_LEVEL <= DEPTH. A bench assertion checks this at elaboration.

## Timing
- Reset values:
  - oCOUNT=0, oEMPTY=1, oFULL=0
  - oALMOST_EMPTY=1, oALMOST_FULL=0 (AF_LEVEL>0)
  - oOVF=0, oUDF=0, oDATA=0
- Reset asserted mid-operation empties the stack immediately. An in-flight push is lost.
- Latency: a push at edge N makes the data visible on oDATA and updates oCOUNT/flags after edge N.
- A pop at edge N exposes the previous entry on oDATA after edge N.
- Replace-top updates oDATA after the edge; oCOUNT does not change.
- Push and pop may be issued every cycle; there is no handshake stall. Rejection is signalled only via oOVF/oUDF.
- Error flags set on the edge where the rejected request is sampled.

## Test plan
- Fill/drain (ADDR_WIDTH=4, AF_LEVEL=14, AE_LEVEL=2):
  - Push 0x01..0x10 on 16 consecutive cycles, so oFULL=1 and oCOUNT=16. oALMOST_FULL rises after the 14th push; oALMOST_EMPTY falls after the 3rd push.
  - 16 pops then return 0x10..0x01 on oDATA, in that order, and oEMPTY=1.
- Overflow/underflow:
  - Push when full: oOVF=1, oCOUNT stays 16, oDATA unchanged.
  - iCLR: oOVF=0, oCOUNT=0.
  - Pop when empty: oUDF=1, oCOUNT stays 0.
- Replace-top:
  - Push 0xAA, push 0xBB, then push+pop with 0xCC: oCOUNT=2, oDATA=0xCC.
  - Pop: oDATA=0xAA.
  - Repeat the push+pop at full: oFULL stays 1, oOVF stays 0.
- Push+pop when empty, iDATA=0x55: oCOUNT=1, oDATA=0x55, oUDF=1.
- iCLR priority: iCLR=1 with iPUSH=1 at count 5 gives oCOUNT=0 and oEMPTY=1, with no write.
- Async reset mid-fill: assert iRESET between edges at count 7. All outputs return to reset values before the next edge.
